u_lsu_pipe: RTL and testbench

//  Pipelined load/store unit between the core pipeline and the data SRAM (sram1).

---
 rtl/u_lsu_pipe_if.sv | 33 +++
 rtl/u_lsu_pipe.sv | 138 +++++++++++++
 tb/tb_u_lsu_pipe.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/u_lsu_pipe_if.sv
// Request/response and SRAM bus bundle for the load/store unit.
// The slave modport is the LSU's view; the master modport is the core/SRAM side.
`timescale 1ns/1ps
interface u_lsu_pipe_if #(
    parameter int AW = 16
);
    logic          lsu_req_vld;
    logic          lsu_req_rdy;
    logic [31:0]   lsu_a;
    logic          lsu_wr;
    logic [1:0]    lsu_size;
    logic          lsu_uns;
    logic [31:0]   lsu_wd;
    logic          lsu_vld;
    logic          lsu_rsp_rdy;
    logic [31:0]   lsu_rd;
    logic          lsu_err;
    logic [AW-1:0] dat_a;
    logic [3:0]    dat_we;
    logic [31:0]   dat_wd;
    logic [3:0]    dat_re;
    logic [31:0]   dat_rd;

    modport slave (
        input  lsu_req_vld, lsu_a, lsu_wr, lsu_size, lsu_uns, lsu_wd, lsu_rsp_rdy, dat_rd,
        output lsu_req_rdy, lsu_vld, lsu_rd, lsu_err, dat_a, dat_we, dat_wd, dat_re
    );

    modport master (
        output lsu_req_vld, lsu_a, lsu_wr, lsu_size, lsu_uns, lsu_wd, lsu_rsp_rdy, dat_rd,
        input  lsu_req_rdy, lsu_vld, lsu_rd, lsu_err, dat_a, dat_we, dat_wd, dat_re
    );
endinterface

// File: rtl/u_lsu_pipe.sv
// Pipelined load/store unit: drives SRAM strobes on accept, delays request info by RD_LAT,
// then extends load data and returns in-order responses through a credit-guarded FIFO.
`timescale 1ns/1ps
module u_lsu_pipe #(
    parameter int AW        = 16,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    u_lsu_pipe_if.slave  bus
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

    typedef struct packed {
        logic       vld;
        logic       isLoad;
        logic [1:0] size;
        logic       uns;
        logic [1:0] ofs;
        logic       err;
    } stage_t;

    stage_t        pipe_q [RD_LAT];
    stage_t        inS;
    stage_t        exitS;
    logic [31:0]   rspRd_q [RSP_DEPTH];
    logic          rspErr_q [RSP_DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] fifoCnt_q, fifoCnt_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          accept, reqErr;
    logic [3:0]    mask;
    logic [31:0]   wdRep, lane, exitRd;
    logic          exitErr, fifoEmpty, pop, bypass, push, fifoPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        reqErr = (bus.lsu_size == 2'd3)
               | ((bus.lsu_size == 2'd1) & bus.lsu_a[0])
               | ((bus.lsu_size == 2'd2) & (bus.lsu_a[1:0] != 2'd0))
               | ((bus.lsu_a >> AW) != 32'd0);
        mask  = 4'b1111;
        wdRep = bus.lsu_wd;
        case (bus.lsu_size)
            2'd0: begin
                mask  = 4'b0001 << bus.lsu_a[1:0];
                wdRep = {4{bus.lsu_wd[7:0]}};
            end
            2'd1: begin
                mask  = 4'b0011 << bus.lsu_a[1:0];
                wdRep = {2{bus.lsu_wd[15:0]}};
            end
            default: ;
        endcase
    end

    // Credits cover both the delay pipe and the FIFO, so a full FIFO can never be overrun.
    assign bus.lsu_req_rdy = rstn & (credit_q < DEPTH_C);
    assign accept          = bus.lsu_req_vld & bus.lsu_req_rdy;
    assign bus.dat_a       = {bus.lsu_a[AW-1:2], 2'b00};
    assign bus.dat_wd      = wdRep;
    assign bus.dat_we      = (accept & ~reqErr &  bus.lsu_wr) ? mask : 4'b0000;
    assign bus.dat_re      = (accept & ~reqErr & ~bus.lsu_wr) ? mask : 4'b0000;

    always_comb begin
        inS.vld    = accept;
        inS.isLoad = ~bus.lsu_wr;
        inS.size   = bus.lsu_size;
        inS.uns    = bus.lsu_uns;
        inS.ofs    = bus.lsu_a[1:0];
        inS.err    = reqErr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= inS;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign exitS   = pipe_q[RD_LAT-1];
    assign exitErr = exitS.vld & exitS.err;

    // The last pipe stage lines up with the cycle dat_rd is valid for that request.
    always_comb begin
        lane   = bus.dat_rd >> {exitS.ofs, 3'b000};
        exitRd = '0;
        if (exitS.vld && exitS.isLoad && !exitS.err) begin
            case (exitS.size)
                2'd0:    exitRd = exitS.uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
                2'd1:    exitRd = exitS.uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
                default: exitRd = lane;
            endcase
        end
    end

    // An empty FIFO forwards the exiting response directly so it is seen at accept+RD_LAT.
    assign fifoEmpty   = (fifoCnt_q == '0);
    assign bus.lsu_vld = ~fifoEmpty | exitS.vld;
    assign bus.lsu_rd  = fifoEmpty ? exitRd  : rspRd_q[rdPtr_q];
    assign bus.lsu_err = fifoEmpty ? exitErr : rspErr_q[rdPtr_q];
    assign pop         = bus.lsu_vld & bus.lsu_rsp_rdy;
    assign bypass      = fifoEmpty & exitS.vld & bus.lsu_rsp_rdy;
    assign push        = exitS.vld & ~bypass;
    assign fifoPop     = pop & ~fifoEmpty;
    assign fifoCnt_d   = fifoCnt_q + CW'(push) - CW'(fifoPop);
    assign credit_d    = credit_q + CW'(accept) - CW'(pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            fifoCnt_q <= '0;
            credit_q  <= '0;
        end else begin
            fifoCnt_q <= fifoCnt_d;
            credit_q  <= credit_d;
            if (push)    wrPtr_q <= nextPtr(wrPtr_q);
            if (fifoPop) rdPtr_q <= nextPtr(rdPtr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rspRd_q[wrPtr_q]  <= exitRd;
            rspErr_q[wrPtr_q] <= exitErr;
        end
    end
endmodule

// File: tb/tb_u_lsu_pipe.sv
// Scoreboard bench for u_lsu_pipe: directed requests push expected responses,
// a forked monitor pops and compares whenever a response is accepted.
`timescale 1ns/1ps
module tb_u_lsu_pipe;
    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } rsp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    rsp_t qA[$];
    rsp_t qB[$];
    rsp_t qC[$];

    always #5 clk = ~clk;

    u_lsu_pipe_if #(.AW(16)) busA ();
    u_lsu_pipe_if #(.AW(16)) busB ();
    u_lsu_pipe_if #(.AW(16)) busC ();

    u_lsu_pipe #(.AW(16), .RD_LAT(1), .RSP_DEPTH(4)) dutA (.clk(clk), .rstn(rstn), .bus(busA));
    u_lsu_pipe #(.AW(16), .RD_LAT(3), .RSP_DEPTH(3)) dutB (.clk(clk), .rstn(rstn), .bus(busB));
    u_lsu_pipe #(.AW(16), .RD_LAT(1), .RSP_DEPTH(1)) dutC (.clk(clk), .rstn(rstn), .bus(busC));

    // Fixed read-only contents for the streaming instances.
    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a[7:0] ^ 8'hC3, 8'h5A, ~a[7:0], a[7:0]};
    endfunction

    logic [31:0] memA [0:255];
    logic [31:0] rdA, rdC;
    logic [31:0] rdB [3];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (busA.dat_we[b]) memA[busA.dat_a[9:2]][8*b +: 8] <= busA.dat_wd[8*b +: 8];
        rdA    <= memA[busA.dat_a[9:2]];
        rdB[0] <= pat(busB.dat_a);
        rdB[1] <= rdB[0];
        rdB[2] <= rdB[1];
        rdC    <= pat(busC.dat_a);
    end

    assign busA.dat_rd = rdA;
    assign busB.dat_rd = rdB[2];
    assign busC.dat_rd = rdC;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpectedRsp(input string name, input logic [31:0] rd);
        checks++;
        errors++;
        $display("[TB] FAIL %s unexpected response actual=%0h required=none", name, rd);
    endtask

    task automatic monitor();
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (busA.lsu_vld && busA.lsu_rsp_rdy) begin
                    if (qA.size() == 0) unexpectedRsp("rspA", busA.lsu_rd);
                    else begin
                        e = qA.pop_front();
                        checkOutput("rspA", {busA.lsu_rd, busA.lsu_err}, e);
                    end
                end
                if (busB.lsu_vld && busB.lsu_rsp_rdy) begin
                    if (qB.size() == 0) unexpectedRsp("rspB", busB.lsu_rd);
                    else begin
                        e = qB.pop_front();
                        checkOutput("rspB", {busB.lsu_rd, busB.lsu_err}, e);
                    end
                end
                if (busC.lsu_vld && busC.lsu_rsp_rdy) begin
                    if (qC.size() == 0) unexpectedRsp("rspC", busC.lsu_rd);
                    else begin
                        e = qC.pop_front();
                        checkOutput("rspC", {busC.lsu_rd, busC.lsu_err}, e);
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] wd,
                                 input logic [3:0] expWe, input logic [3:0] expRe,
                                 input logic [31:0] expWd, input logic [31:0] expRd,
                                 input logic expErr);
        bit accepted = 1'b0;
        busA.lsu_req_vld = 1'b1;
        busA.lsu_a       = a;
        busA.lsu_wr      = wr;
        busA.lsu_size    = sz;
        busA.lsu_uns     = uns;
        busA.lsu_wd      = wd;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (busA.lsu_req_rdy) begin
                accepted = 1'b1;
                checkOutput($sformatf("strobes@%0h", a), {busA.dat_we, busA.dat_re}, {expWe, expRe});
                checkOutput($sformatf("dat_a@%0h", a), busA.dat_a, a[15:0] & 16'hFFFC);
                if (wr) checkOutput($sformatf("dat_wd@%0h", a), busA.dat_wd, expWd);
                qA.push_back({expRd, expErr});
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout@%0h actual=not_accepted required=accepted", a);
        end
        busA.lsu_req_vld = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        bit got;
        busA.lsu_req_vld = 0; busA.lsu_a = 0; busA.lsu_wr = 0; busA.lsu_size = 0;
        busA.lsu_uns = 0; busA.lsu_wd = 0; busA.lsu_rsp_rdy = 1;
        busB.lsu_req_vld = 0; busB.lsu_a = 0; busB.lsu_wr = 0; busB.lsu_size = 2;
        busB.lsu_uns = 0; busB.lsu_wd = 0; busB.lsu_rsp_rdy = 1;
        busC.lsu_req_vld = 0; busC.lsu_a = 0; busC.lsu_wr = 0; busC.lsu_size = 2;
        busC.lsu_uns = 0; busC.lsu_wd = 0; busC.lsu_rsp_rdy = 1;
        fork
            monitor();
        join_none

        // A request held valid during reset must produce no strobes and no accept.
        busA.lsu_req_vld = 1; busA.lsu_a = 32'h10; busA.lsu_wr = 1; busA.lsu_size = 2;
        busA.lsu_wd = 32'h0BADF00D;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {busA.lsu_req_rdy, busA.lsu_vld, busA.lsu_err, busA.lsu_rd}, 64'h0);
        checkOutput("reset_strobes", {busA.dat_we, busA.dat_re}, 8'h00);
        busA.lsu_req_vld = 0;
        @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        checkOutput("rdy_after_reset", busA.lsu_req_rdy, 1);
        settle(1);

        // Store word then load it back.
        applyStimulus(32'h10, 1, 2, 0, 32'hDEADBEEF, 4'b1111, 4'b0000, 32'hDEADBEEF, 32'h0, 0);
        applyStimulus(32'h10, 0, 2, 0, 32'h0,        4'b0000, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
        @(negedge clk);
        checkOutput("load_latency", {busA.lsu_vld, busA.lsu_rd}, {1'b1, 32'hDEADBEEF});
        settle(1);

        // Sign/zero extension of byte and half lanes.
        applyStimulus(32'h10, 1, 2, 0, 32'h80000000, 4'b1111, 4'b0000, 32'h80000000, 32'h0, 0);
        applyStimulus(32'h13, 0, 0, 0, 32'h0, 4'b0000, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
        applyStimulus(32'h13, 0, 0, 1, 32'h0, 4'b0000, 4'b1000, 32'h0, 32'h00000080, 0);
        applyStimulus(32'h12, 0, 1, 0, 32'h0, 4'b0000, 4'b1100, 32'h0, 32'hFFFF8000, 0);
        applyStimulus(32'h12, 0, 1, 1, 32'h0, 4'b0000, 4'b1100, 32'h0, 32'h00008000, 0);

        // Fill 0x20..0x2C, then merge a byte and a half store into 0x20.
        for (int k = 0; k < 4; k++)
            applyStimulus(32'h20 + 32'(4*k), 1, 2, 0, 32'h11111111 * 32'(k+1), 4'b1111, 4'b0000,
                          32'h11111111 * 32'(k+1), 32'h0, 0);
        applyStimulus(32'h21, 1, 0, 0, 32'h123456AB, 4'b0010, 4'b0000, 32'hABABABAB, 32'h0, 0);
        applyStimulus(32'h22, 1, 1, 0, 32'hCAFEBEEF, 4'b1100, 4'b0000, 32'hBEEFBEEF, 32'h0, 0);
        applyStimulus(32'h20, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'hBEEFAB11, 0);
        applyStimulus(32'h22, 0, 1, 0, 32'h0, 4'b0000, 4'b1100, 32'h0, 32'hFFFFBEEF, 0);
        applyStimulus(32'h21, 0, 0, 1, 32'h0, 4'b0000, 4'b0010, 32'h0, 32'h000000AB, 0);

        // Error requests: no strobes, error response, pipeline keeps going.
        applyStimulus(32'h01, 1, 1, 0, 32'h00001234, 4'b0000, 4'b0000, 32'h12341234, 32'h0, 1);
        applyStimulus(32'h24, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h22222222, 0);
        applyStimulus(32'h00010000, 0, 2, 0, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1);
        applyStimulus(32'h20, 0, 3, 0, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1);
        applyStimulus(32'h12, 0, 2, 0, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1);
        applyStimulus(32'hFFFF, 1, 0, 0, 32'h000000EE, 4'b1000, 4'b0000, 32'hEEEEEEEE, 32'h0, 0);
        settle(3);

        // Back-pressure: four loads fill the credits, the fifth waits.
        busA.lsu_rsp_rdy = 0;
        applyStimulus(32'h10, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h80000000, 0);
        applyStimulus(32'h24, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h22222222, 0);
        applyStimulus(32'h28, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h33333333, 0);
        applyStimulus(32'h2C, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h44444444, 0);
        busA.lsu_req_vld = 1; busA.lsu_a = 32'h20; busA.lsu_wr = 0; busA.lsu_size = 2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("full_rdy", busA.lsu_req_rdy, 0);
            checkOutput("head_hold", {busA.lsu_vld, busA.lsu_rd, busA.lsu_err}, {1'b1, 32'h80000000, 1'b0});
        end
        @(posedge clk);
        #1 busA.lsu_rsp_rdy = 1;
        applyStimulus(32'h20, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'hBEEFAB11, 0);
        settle(6);

        // Reset with three loads outstanding drops everything.
        busA.lsu_rsp_rdy = 0;
        applyStimulus(32'h24, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h22222222, 0);
        applyStimulus(32'h28, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h33333333, 0);
        applyStimulus(32'h2C, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h44444444, 0);
        #2 rstn = 0;
        #1;
        checkOutput("midrst_vld_rdy", {busA.lsu_vld, busA.lsu_req_rdy}, 2'b00);
        checkOutput("midrst_rd_err", {busA.lsu_rd, busA.lsu_err}, 33'h0);
        qA.delete();
        @(posedge clk);
        #1 rstn = 1;
        busA.lsu_rsp_rdy = 1;
        @(negedge clk);
        checkOutput("postrst_rdy", busA.lsu_req_rdy, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("postrst_no_stale", busA.lsu_vld, 0);
        end
        settle(1);
        applyStimulus(32'h2C, 0, 2, 0, 32'h0, 4'b0000, 4'b1111, 32'h0, 32'h44444444, 0);
        settle(3);

        // Streaming word loads through the RD_LAT=3 and RD_LAT=1 instances.
        cyc = 0;
        for (int k = 0; k < 12; k++) begin
            busB.lsu_req_vld = 1; busB.lsu_a = 32'(4*k);
            do begin
                @(negedge clk);
                got = busB.lsu_req_rdy;
                if (got) qB.push_back({pat(16'(4*k)), 1'b0});
                @(posedge clk);
                #1 cyc++;
            end while (!got && cyc < 200);
        end
        busB.lsu_req_vld = 0;
        checkOutput("streamB_cycles_ok", cyc <= 30, 1);
        cyc = 0;
        for (int k = 0; k < 12; k++) begin
            busC.lsu_req_vld = 1; busC.lsu_a = 32'(4*k + 64);
            do begin
                @(negedge clk);
                got = busC.lsu_req_rdy;
                if (got) qC.push_back({pat(16'(4*k + 64)), 1'b0});
                @(posedge clk);
                #1 cyc++;
            end while (!got && cyc < 200);
        end
        busC.lsu_req_vld = 0;
        checkOutput("streamC_cycles_ok", cyc <= 30, 1);

        for (int i = 0; i < 50 && (qA.size() + qB.size() + qC.size()) != 0; i++) @(posedge clk);
        @(negedge clk);
        checkOutput("drain_empty", qA.size() + qB.size() + qC.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
